// File: rtl/alu_result_stage.sv
// alu_result_stage: registered valid/ready output stage for the ALU result mux.
// Latency 1 cycle; two-entry skid (main + skid) keeps in_ready a pure state decode.
// Optional macro ALU_RESULT_FLAGS_EN enables {N,Z,C,V} flag capture; otherwise out_flags = 0.
module alu_result_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_carry,
  input  logic             in_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_result;
  logic [WIDTH-1:0] skid_result;

  logic accept;
  logic load_main_in;
  logic load_skid;
  logic load_main_skid;

  // Load enables for the data registers; flush suppresses every load so a
  // discarded beat never lands in storage.
  always_comb begin
    accept         = in_valid && in_ready && !flush;
    load_main_in   = accept && ((state == EMPTY) || out_ready);
    load_skid      = accept && (state == ONE) && !out_ready;
    load_main_skid = !flush && (state == TWO) && out_ready;
  end

  // Occupancy FSM; out_valid and in_ready are registered alongside the state
  // so neither has a combinational path from any input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_valid) begin
            state     <= ONE;
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
          end
        end
        ONE: begin
          if (in_valid && !out_ready) begin
            state     <= TWO;
            out_valid <= 1'b1;
            in_ready  <= 1'b0;
          end else if (!in_valid && out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        TWO: begin
          if (out_ready) begin
            state     <= ONE;
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  // Result storage: main drives the outputs, skid absorbs the beat that
  // arrives during the first stall cycle. Main never moves while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_result <= '0;
      skid_result <= '0;
    end else begin
      if (load_main_in) begin
        main_result <= in_result;
      end else if (load_main_skid) begin
        main_result <= skid_result;
      end
      if (load_skid) begin
        skid_result <= in_result;
      end
    end
  end

  assign out_result = main_result;

`ifdef ALU_RESULT_FLAGS_EN
  logic [3:0] in_flags;
  logic [3:0] main_flags;
  logic [3:0] skid_flags;

  // Flags are derived from the incoming beat at capture time.
  always_comb begin
    in_flags = {in_result[WIDTH-1], (in_result == '0), in_carry, in_ovf};
  end

  // Flag storage follows exactly the same load pattern as the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_flags <= 4'b0000;
      skid_flags <= 4'b0000;
    end else begin
      if (load_main_in) begin
        main_flags <= in_flags;
      end else if (load_main_skid) begin
        main_flags <= skid_flags;
      end
      if (load_skid) begin
        skid_flags <= in_flags;
      end
    end
  end

  assign out_flags = main_flags;
`else
  // Flag inputs have no consumer in this build.
  logic unused_flag_inputs;
  assign unused_flag_inputs = in_carry ^ in_ovf;
  assign out_flags          = 4'b0000;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: scoreboard bench for alu_result_stage.
// Stimulus pushes expected beats into a queue; a monitor checks and pops on delivery.
// Reference model is an in-order queue with capacity 2, cleared by flush and reset.
module tb_alu_result_stage;

  localparam int WIDTH = 32;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic             in_carry;
  logic             in_ovf;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_flags;

  int    errors = 0;
  int    checks = 0;
  beat_t exp_q[$];
  logic  deliver_seen;
  logic  exp_ready;

  alu_result_stage #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_carry   (in_carry),
    .in_ovf     (in_ovf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] model_flags(input logic [WIDTH-1:0] r, input logic c, input logic o);
`ifdef ALU_RESULT_FLAGS_EN
    logic n;
    logic z;
    n = (r >= 32'h8000_0000);
    z = (r == 32'd0);
    return {n, z, c, o};
`else
    return 4'b0000;
`endif
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] actual, input logic [WIDTH-1:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, required, $time);
    end
  endtask

  // Monitor: compare DUT outputs with the model each cycle, pop on delivery.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      deliver_seen = 1'b0;
      if (!rst) begin
        check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < 2});
        if (exp_q.size() != 0 && out_valid) begin
          check("out_result", out_result, exp_q[0].result);
          check("out_flags", {28'd0, out_flags}, {28'd0, exp_q[0].flags});
          deliver_seen = out_ready;
        end
      end
      #2;
      if (deliver_seen && !flush && exp_q.size() != 0) void'(exp_q.pop_front());
    end
  end

  // One stimulus cycle: drive at negedge, then update the model for the
  // edge that follows.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic c, input logic o,
                       input logic ordy, input logic fl);
    beat_t b;
    @(negedge clk);
    in_valid  = v;
    in_result = d;
    in_carry  = c;
    in_ovf    = o;
    out_ready = ordy;
    flush     = fl;
    #2;
    exp_ready = (exp_q.size() < 2);
    if (fl) begin
      exp_q.delete();
    end else if (v && exp_ready) begin
      b.result = d;
      b.flags  = model_flags(d, c, o);
      exp_q.push_back(b);
    end
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_result = '0;
    in_carry  = 1'b0;
    in_ovf    = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_flags", {28'd0, out_flags}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Zero result with carry.
    cycle(1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back stream.
    for (int i = 1; i <= 3; i++) cycle(1'b1, i, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Stall fills main and skid, then drain in order.
    cycle(1'b1, 32'h8000_0001, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_000A, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000_00EE, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Flush from TWO together with an incoming beat.
    cycle(1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h55, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset while holding one beat.
    cycle(1'b1, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_out_result", out_result, 32'd0);
    check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;

    // Negative result with carry.
    cycle(1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic with occasional zero results and flushes.
    for (int i = 0; i < 400; i++) begin
      logic [WIDTH-1:0] d;
      d = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      cycle($urandom_range(0, 3) != 0, d, 1'($urandom), 1'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
    end

    // Drain.
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("drained", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
